// File: rtl/instr_cache.sv
`default_nettype none
// ============================================================================
// Module      : instr_cache
// Description : Direct-mapped read-only instruction cache with word-by-word
//               line refill from backing memory over a req/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iaddr,
    output logic [31:0] data,
    output logic        stall,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TW = 32 - OB - IB - 2;

    localparam logic [OB-1:0] c_cnt_one  = OB'(1);
    localparam logic [OB-1:0] c_cnt_last = OB'(WORDS - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FILL = 1'b1
    } state_t;

    state_t          r_state;
    logic [LINES-1:0] r_valid;
    logic [TW-1:0]   r_tags  [LINES];
    logic [31:0]     r_words [LINES*WORDS];
    logic [OB-1:0]   r_cnt;
    logic [IB-1:0]   r_fill_idx;
    logic [31:0]     r_base;
    logic            r_flush_pend;

    logic [TW-1:0]   w_tag;
    logic [IB-1:0]   w_index;
    logic [OB-1:0]   w_offset;
    logic            w_hit;
    logic            w_fill_beat;
    logic            w_fill_done;
    logic            w_unused;

    assign w_tag    = iaddr[31:OB+IB+2];
    assign w_index  = iaddr[OB+IB+1:OB+2];
    assign w_offset = iaddr[OB+1:2];
    assign w_unused = ^iaddr[1:0];

    assign w_hit       = (r_state == S_IDLE) && r_valid[w_index] && (r_tags[w_index] == w_tag);
    assign w_fill_beat = (r_state == S_FILL) && mem_ready;
    assign w_fill_done = w_fill_beat && (r_cnt == c_cnt_last);

    assign stall = !w_hit;
    assign data  = w_hit ? r_words[{w_index, w_offset}] : 32'h0;

    // Refill address is built from registers only so memory sees a stable request.
    assign mem_req  = (r_state == S_FILL);
    assign mem_addr = r_base | {{(30-OB){1'b0}}, r_cnt, 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_cnt        <= '0;
            r_base       <= '0;
            r_fill_idx   <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_valid <= '0;
                    end
                    if (!w_hit) begin
                        r_base     <= {iaddr[31:OB+2], {(OB+2){1'b0}}};
                        r_fill_idx <= w_index;
                        r_cnt      <= '0;
                        r_state    <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (mem_ready) begin
                        r_cnt <= r_cnt + c_cnt_one;
                        if (r_cnt == c_cnt_last) begin
                            // A flush seen at any point of the fill leaves every line invalid.
                            if (r_flush_pend || flush) begin
                                r_valid <= '0;
                            end else begin
                                r_valid[r_fill_idx] <= 1'b1;
                            end
                            r_flush_pend <= 1'b0;
                            r_state      <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; validity alone qualifies their contents.
    always_ff @(posedge clk) begin
        if (w_fill_beat) begin
            r_words[{r_fill_idx, r_cnt}] <= mem_rdata;
        end
        if (w_fill_done) begin
            r_tags[r_fill_idx] <= r_base[31:OB+IB+2];
        end
    end

endmodule
`default_nettype wire
